ptr_gen: RTL
============

PTR_GEN -- requirements
Module: ptr_gen

Interface
REQ-001 Parameter STATE, default 0: side select; 0 = read side, blocked by empty; 1 = write side, blocked by full.
REQ-002 Parameter ADDR_WIDTH, default 8: pointer width including wrap MSB; FIFO depth = 2^(ADDR_WIDTH-1) = 128.
REQ-003 Parameter SYNC_STAGES, default 2, legal range 2..4: synchronizer depth for the remote pointer.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  1  access request (write or read, per STATE).
REQ-007 flag  input  1  blocking flag from the paired flag block (empty when STATE=0, full when STATE=1).
REQ-008 ptr_remote  input  ADDR_WIDTH  Gray pointer from the opposite clock domain.
REQ-009 ack  output  1  access accepted this cycle; drives the RAM enable.
REQ-010 addr_mem  output  ADDR_WIDTH-1  binary RAM address.
REQ-011 addr_gray  output  ADDR_WIDTH  registered Gray pointer; feeds the flag block and the opposite domain.
REQ-012 ptr_remote_sync  output  ADDR_WIDTH  synchronized remote Gray pointer.
REQ-013 level  output  ADDR_WIDTH  occupancy (STATE=1) or available-data count (STATE=0).
REQ-014 err  output  1  sticky protocol-violation flag (see Configuration).

Function
REQ-015 ack SHALL be combinational: ack = req & ~flag & ~rst; when flag and req are both high, flag SHALL win (ack=0, no increment).
REQ-016 Internal binary pointer bin (ADDR_WIDTH bits) SHALL increment by 1 on each rising edge where ack=1; otherwise it SHALL hold.
REQ-017 bin SHALL wrap modulo 2^ADDR_WIDTH (0xFF -> 0x00 for ADDR_WIDTH=8); there SHALL be no saturation.
REQ-018 addr_gray SHALL be registered as bin_next ^ (bin_next >> 1) on the same edge as bin, so it never differs from Gray(bin) and changes at most one bit per edge.
REQ-019 addr_mem SHALL equal bin[ADDR_WIDTH-2:0] with zero latency; the RAM index wraps every 2^(ADDR_WIDTH-1) accepts.
REQ-020 ptr_remote SHALL pass through a SYNC_STAGES-deep flop chain; ptr_remote_sync equals ptr_remote delayed by exactly SYNC_STAGES edges.
REQ-021 Remote binary SHALL be rbin = Gray-to-binary(ptr_remote_sync), computed by an MSB-down XOR prefix.
REQ-022 level SHALL be registered one edge after its inputs: STATE=1: bin - rbin; STATE=0: rbin - bin; both modulo 2^ADDR_WIDTH, legal range 0..2^(ADDR_WIDTH-1).
REQ-023 When req is held high while flag is high, ack SHALL stay 0 and SHALL assert in the first cycle flag is low; no request memory is kept.

Reset
REQ-024 While rst=1 at a rising edge: bin, addr_gray, all sync stages, level and err SHALL become 0.
REQ-025 During the rst=1 cycle, ack SHALL be 0 and req SHALL be ignored, including when rst asserts mid-stream.
REQ-026 Reset values: ack=0, addr_mem=0, addr_gray=0, ptr_remote_sync=0, level=0, err=0.

Configuration
REQ-027 Macro PTR_GEN_ERR_EN, when defined: err SHALL set on any edge where req=1 and flag=1, and hold until rst.
REQ-028 Macro PTR_GEN_ERR_EN, when undefined: err SHALL be tied to 0, with no flop inferred; all other behaviour SHALL be identical.

Verification (STATE=1, ADDR_WIDTH=8, SYNC_STAGES=2 unless noted)
REQ-029 rst=1 for 2 cycles, then release with req=0 -> addr_gray=0x00, addr_mem=0, level=0, ack=0, err=0.
REQ-030 req=1, flag=0 for 128 cycles, ptr_remote=0 -> addr_gray=Gray(128)=0xC0, addr_mem=0, level=128 one edge after the last accept.
REQ-031 bin at 0xFF, one accept -> addr_gray 0x80 -> 0x00, addr_mem 0x7F -> 0x00, exactly one bit toggles.
REQ-032 req=1 and flag=1 for 3 cycles, then flag=0 -> ack=0 for 3 cycles, then 1; bin advances by 1; err=1 only when PTR_GEN_ERR_EN is defined.
REQ-033 STATE=0; ptr_remote steps to Gray(50)=0x2B -> ptr_remote_sync=0x2B after 2 edges, level=50 after the 3rd edge.
REQ-034 rst=1 asserted in the middle of a 10-cycle accept burst -> all outputs 0 at the next edge; counting resumes from 0 after release.

Source files
------------

// File: rtl/ptr_gen.sv
// FIFO pointer generator: binary/Gray pointer, remote pointer synchronizer and level.
// Define PTR_GEN_ERR_EN to enable the sticky req-while-blocked error flag.
module ptr_gen #(
  parameter int STATE       = 0,
  parameter int ADDR_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  flag,
  input  logic [ADDR_WIDTH-1:0] ptr_remote,
  output logic                  ack,
  output logic [ADDR_WIDTH-2:0] addr_mem,
  output logic [ADDR_WIDTH-1:0] addr_gray,
  output logic [ADDR_WIDTH-1:0] ptr_remote_sync,
  output logic [ADDR_WIDTH-1:0] level,
  output logic                  err
);

  function automatic logic [ADDR_WIDTH-1:0] gray2bin(input logic [ADDR_WIDTH-1:0] g);
    logic [ADDR_WIDTH-1:0] b;
    b = '0;
    b[ADDR_WIDTH-1] = g[ADDR_WIDTH-1];
    for (int i = ADDR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_WIDTH-1:0] r_bin;
  logic [ADDR_WIDTH-1:0] r_gray;
  logic [ADDR_WIDTH-1:0] r_level;
  logic [ADDR_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [ADDR_WIDTH-1:0] w_bin_next;
  logic [ADDR_WIDTH-1:0] w_rbin;
  logic                  w_ack;

  // Flag wins over req; reset masks the request combinationally.
  assign w_ack      = req & ~flag & ~rst;
  assign w_bin_next = r_bin + {{(ADDR_WIDTH-1){1'b0}}, w_ack};
  assign w_rbin     = gray2bin(r_sync[SYNC_STAGES-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_bin_next ^ (w_bin_next >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= ptr_remote;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Write side reports occupancy, read side reports data available.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
    end else if (STATE == 1) begin
      r_level <= r_bin - w_rbin;
    end else begin
      r_level <= w_rbin - r_bin;
    end
  end

`ifdef PTR_GEN_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (req & flag) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign ack             = w_ack;
  assign addr_mem        = r_bin[ADDR_WIDTH-2:0];
  assign addr_gray       = r_gray;
  assign ptr_remote_sync = r_sync[SYNC_STAGES-1];
  assign level           = r_level;

endmodule
